ibis_axi4_ctrl: RTL

//  AXI4-Lite slave controller sequencing single-beat AXI transactions onto one single-ported register bank.

---
 rtl/ibis_axi4_pkg.sv | 24 ++
 rtl/ibis_axi4_arb.sv | 30 +++
 rtl/ibis_axi4_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ibis_axi4_pkg.sv
// Shared types for the ibis AXI4-Lite register-bank controller.
package ibis_axi4_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    W_ACC,
    W_EXE,
    B_RSP,
    R_ACC,
    R_EXE,
    R_CAP,
    R_RSP
  } ctrl_state_t;

endpackage

// File: rtl/ibis_axi4_arb.sv
// Two-requester round-robin arbiter: req[0] = write, req[1] = read.
module ibis_axi4_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the side that wins when both request; reset favours writes.
  logic ptr;

  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (advance && |grant) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/ibis_axi4_ctrl.sv
// AXI4-Lite slave sequencing single-beat reads/writes onto a single-ported
// register bank, one transaction in flight, round-robin between AW+W and AR.
module ibis_axi4_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                enable,
  input  logic [ADDR_WIDTH-1:0]               awaddr,
  input  logic                                awvalid,
  output logic                                awready,
  input  logic [ibis_axi4_pkg::DATA_WIDTH-1:0] wdata,
  input  logic [3:0]                          wstrb,
  input  logic                                wvalid,
  output logic                                wready,
  output logic [1:0]                          bresp,
  output logic                                bvalid,
  input  logic                                bready,
  input  logic [ADDR_WIDTH-1:0]               araddr,
  input  logic                                arvalid,
  output logic                                arready,
  output logic [ibis_axi4_pkg::DATA_WIDTH-1:0] rdata,
  output logic [1:0]                          rresp,
  output logic                                rvalid,
  input  logic                                rready,
  output logic [$clog2(NUM_REGS)-1:0]         reg_idx,
  output logic [ibis_axi4_pkg::DATA_WIDTH-1:0] reg_wdata,
  output logic [3:0]                          reg_wstrb,
  output logic                                reg_we,
  output logic                                reg_re,
  input  logic [ibis_axi4_pkg::DATA_WIDTH-1:0] reg_rdata
);

  import ibis_axi4_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  ctrl_state_t state;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        advance;
  logic        we_q;
  logic        re_q;
  logic        rd_ok;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (32'(a[ADDR_WIDTH-1:2]) < NUM_REGS);
  endfunction

  assign req     = {arvalid, awvalid & wvalid};
  assign advance = (state == IDLE) && enable && (|req);

  ibis_axi4_arb u_arb (
    .clk     (aclk),
    .rstn    (aresetn),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  // Strobes are gated by reset so a transaction abandoned mid-flight never
  // touches the bank in the reset cycle itself.
  assign reg_we = we_q & aresetn;
  assign reg_re = re_q & aresetn;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rresp     <= OKAY;
      rdata     <= '0;
      reg_idx   <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      case (state)
        IDLE: begin
          if (advance) begin
            if (grant[0]) begin
              awready <= 1'b1;
              wready  <= 1'b1;
              state   <= W_ACC;
            end else if (grant[1]) begin
              arready <= 1'b1;
              state   <= R_ACC;
            end
          end
        end
        W_ACC: begin
          awready   <= 1'b0;
          wready    <= 1'b0;
          reg_idx   <= awaddr[IDX_W+1:2];
          reg_wdata <= wdata;
          reg_wstrb <= wstrb;
          we_q      <= addr_ok(awaddr);
          bresp     <= addr_ok(awaddr) ? OKAY : SLVERR;
          state     <= W_EXE;
        end
        W_EXE: begin
          bvalid <= 1'b1;
          state  <= B_RSP;
        end
        B_RSP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        R_ACC: begin
          arready <= 1'b0;
          reg_idx <= araddr[IDX_W+1:2];
          re_q    <= addr_ok(araddr);
          rd_ok   <= addr_ok(araddr);
          rresp   <= addr_ok(araddr) ? OKAY : SLVERR;
          state   <= R_EXE;
        end
        R_EXE: begin
          state <= R_CAP;
        end
        R_CAP: begin
          rdata  <= rd_ok ? reg_rdata : '0;
          rvalid <= 1'b1;
          state  <= R_RSP;
        end
        R_RSP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
